dmem_atomic_responder: RTL

- Data-memory responder on the memory-stage side of the pipeline's dREN/dWEN/dhit/datomic protocol; the memory latch is the requester.
- Models a word-addressed data RAM with fixed, programmable hit latency.
- Implements the load-linked/store-conditional link register for atomics and a snoop port that breaks the link.
- Used as the dcache stand-in for pipeline bring-up and in the single-core testbench.

---
 rtl/dmem_atomic_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_atomic_responder.sv
// dmem_atomic_responder
// This module stands in for the data cache during pipeline bring-up.
// It responds to the memory-stage dREN/dWEN/datomic request protocol.
//
// It models a word-addressed RAM with a fixed hit latency of LATENCY wait
// cycles. It also holds the load-linked/store-conditional link register,
// which a snoop port can clear.
//
// Optional statistics counters are enabled by defining DMEM_STATS_EN.
// With the macro defined, three more outputs are present: rd_count,
// wr_count and sc_fail_count.
module dmem_atomic_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic        datomic,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        snoop_valid,
    input  logic [31:0] snoop_addr,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        link_valid
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] sc_fail_count
`endif
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    // Counter only needs to hold LATENCY; keep at least one bit for LATENCY 0/1.
    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(LATENCY);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HIT  = 2'd2
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    req_write;
    logic                    req_atomic;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [31:0]             req_data;
    logic [DEPTH_LOG2-1:0]   link_addr;
    logic [31:0]             ram [WORDS];

    logic                    req_any;
    logic [DEPTH_LOG2-1:0]   in_idx;
    logic [DEPTH_LOG2-1:0]   snoop_idx;

    // The action applied on the edge that enters HIT.
    logic                    enter_hit;
    logic                    act_write;
    logic                    act_atomic;
    logic [DEPTH_LOG2-1:0]   act_idx;
    logic [31:0]             act_data;
    logic                    link_match;
    logic                    snoop_hit;
    logic                    sc_success;
    logic                    ram_we;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{daddr[31:DEPTH_LOG2+2], daddr[1:0],
                                snoop_addr[31:DEPTH_LOG2+2], snoop_addr[1:0]};

    assign req_any   = dREN | dWEN;
    assign in_idx    = daddr[DEPTH_LOG2+1:2];
    assign snoop_idx = snoop_addr[DEPTH_LOG2+1:2];

    // Select the request that resolves this edge.
    // With zero latency the live inputs resolve straight from IDLE.
    // Otherwise the request captured in IDLE resolves on the last BUSY edge.
    always_comb begin
        enter_hit  = 1'b0;
        act_write  = req_write;
        act_atomic = req_atomic;
        act_idx    = req_idx;
        act_data   = req_data;
        if (state == IDLE && req_any && LATENCY == 0) begin
            enter_hit  = 1'b1;
            act_write  = dWEN;
            act_atomic = datomic;
            act_idx    = in_idx;
            act_data   = dstore;
        end else if (state == BUSY && req_any && cnt == CNT_ONE) begin
            enter_hit = 1'b1;
        end
    end

    // A snoop on the resolving edge is seen first, so a racing SC fails.
    assign link_match = link_valid && (link_addr == act_idx);
    assign snoop_hit  = snoop_valid && (snoop_idx == link_addr);
    assign sc_success = link_match && !snoop_hit;
    assign ram_we     = enter_hit && act_write && (!act_atomic || sc_success);

    // Request FSM with registered dhit/dload.
    // A flush (both requests low) while BUSY abandons the request silently.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            cnt        <= '0;
            req_write  <= 1'b0;
            req_atomic <= 1'b0;
            req_idx    <= '0;
            req_data   <= '0;
            dhit       <= 1'b0;
            dload      <= '0;
        end else begin
            dhit  <= 1'b0;
            dload <= '0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        req_write  <= dWEN;
                        req_atomic <= datomic;
                        req_idx    <= in_idx;
                        req_data   <= dstore;
                        cnt        <= LAT_INIT;
                        state      <= (LATENCY == 0) ? HIT : BUSY;
                    end
                end
                BUSY: begin
                    if (!req_any) begin
                        state <= IDLE;
                    end else if (cnt == CNT_ONE) begin
                        state <= HIT;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                HIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (enter_hit) begin
                dhit <= 1'b1;
                if (!act_write) begin
                    dload <= ram[act_idx];
                end else if (act_atomic) begin
                    dload <= {31'b0, sc_success};
                end
            end
        end
    end

    // Link register.
    // A snoop to the linked word breaks the link, but an LL resolving on the
    // same edge overrides the snoop and sets the link.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            if (snoop_hit) begin
                link_valid <= 1'b0;
            end
            if (enter_hit) begin
                if (!act_write && act_atomic) begin
                    link_valid <= 1'b1;
                    link_addr  <= act_idx;
                end else if (act_write && (act_atomic || link_match)) begin
                    link_valid <= 1'b0;
                end
            end
        end
    end

    // Data RAM.
    // Its contents are cleared by reset, so it lives in flops rather than in
    // a block RAM.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < WORDS; i++) begin
                ram[i] <= '0;
            end
        end else if (ram_we) begin
            ram[act_idx] <= act_data;
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating counters, updated in the HIT cycle so aborted requests never count.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_count      <= '0;
            wr_count      <= '0;
            sc_fail_count <= '0;
        end else if (state == HIT) begin
            if (!req_write && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
            if (req_write && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
            if (req_write && req_atomic && !dload[0] && sc_fail_count != 16'hFFFF) begin
                sc_fail_count <= sc_fail_count + 16'd1;
            end
        end
    end
`endif

endmodule
